// File: rtl/rr_arbiter4_pkg.sv
// Shared types and defaults for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned ARB_MAX_HOLD_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first requester from start, optionally skipping one index.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] w_cand;

  // Scan from the far end so the earliest match in search order wins.
  always_comb begin
    found  = 1'b0;
    idx    = start;
    w_cand = start;
    for (int i = 3; i >= 0; i--) begin
      w_cand = start + 2'(i);
      if (req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and registered mux select.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       j1,
  output logic       j0,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_e    r_state, w_nxt_state;
  logic [1:0]    r_ptr, w_nxt_ptr;
  logic [1:0]    r_owner, w_nxt_owner;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [3:0]    r_grant, w_nxt_grant;
  logic          r_busy;

  logic          w_excl_en;
  logic          w_found;
  logic [1:0]    w_idx;

  rr_pick4 u_pick (
    .req      (req),
    .start    (r_ptr),
    .excl_en  (w_excl_en),
    .excl_idx (r_owner),
    .found    (w_found),
    .idx      (w_idx)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_owner <= w_nxt_owner;
      r_cnt   <= w_nxt_cnt;
      r_grant <= w_nxt_grant;
      r_busy  <= (w_nxt_state == ST_OWNED);
    end
  end

  // Next-state: the owner keeps the grant until it drops or its hold budget runs out under contention.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_owner = r_owner;
    w_nxt_cnt   = r_cnt;
    w_nxt_grant = r_grant;
    w_excl_en   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state = ST_OWNED;
          w_nxt_owner = w_idx;
          w_nxt_ptr   = w_idx + 2'd1;
          w_nxt_cnt   = '0;
          w_nxt_grant = onehot4(w_idx);
        end
      end
      ST_OWNED: begin
        w_excl_en = 1'b1;
        if (req[r_owner] && (!w_found || (r_cnt != HOLD_LAST))) begin
          if (r_cnt != HOLD_LAST) begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end else if (w_found) begin
          w_nxt_owner = w_idx;
          w_nxt_ptr   = w_idx + 2'd1;
          w_nxt_cnt   = '0;
          w_nxt_grant = onehot4(w_idx);
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
          w_nxt_grant = 4'b0000;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_grant = 4'b0000;
      end
    endcase
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign j1    = r_owner[0];
  assign j0    = r_owner[1];

endmodule
